pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
Holds the architectural program counter and drives instruction fetch for the RV32I core. It sits directly downstream of the next-PC mux and consumes next_pc, choosing between pc_plus4 and alu_result. It registers that value as the new PC, fetches the instruction through a req/ready handshake, and presents the instruction to decode with a valid/ack handshake. It also flags a misaligned next_pc and then halts fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
next_pc  input  XLEN  next PC from the next-PC mux
pc  output  XLEN  current PC register
pc_plus4  output  XLEN  pc + 4, combinational, feeds the next-PC mux
imem_req  output  1  fetch request to instruction memory
imem_addr  output  XLEN  fetch address, always equal to pc
imem_ready  input  1  memory returns data this cycle; sampled only while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_ready=1
instr  output  32  registered instruction presented to decode
instr_valid  output  1  instr holds the instruction at pc
instr_ack  input  1  core has consumed instr and next_pc is valid this cycle
stall  input  1  hold the current instruction; blocks PC update
misaligned  output  1  sticky flag: next_pc[1:0] != 0 was accepted

Behaviour:
- FSM states: FETCH, VALID, TRAP. Encoding comes from the shared package.
- Reset (rst=1 at a clock edge), regardless of state or an outstanding request:
  - state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), misaligned=0.
  - instr_valid=0 and imem_req=0 in the cycle after reset is sampled.
- Reset has priority over every other input. A fetch that is in flight when rst is sampled is abandoned; a late imem_ready is ignored.
- FETCH:
  - imem_req=1 (except the first cycle after reset), imem_addr=pc, instr_valid=0.
  - On imem_ready=1: instr<=imem_rdata, go to VALID. A zero-wait response in the same cycle as req is legal.
  - Otherwise stay in FETCH with req held. The address must stay stable until ready arrives.
- VALID:
  - imem_req=0, instr_valid=1.
  - instr_ack=1 and stall=0: pc<=next_pc.
    - If next_pc[1:0]==2'b00, go to FETCH.
    - Else set misaligned<=1 and go to TRAP.
  - stall=1 takes priority over instr_ack: pc and instr are held and the state stays VALID.
  - instr_ack=0: hold.
- TRAP:
  - imem_req=0, instr_valid=0, misaligned=1.
  - Stays in TRAP until reset. pc holds the offending address for debug.
- instr_ack in FETCH or TRAP is ignored. imem_ready outside FETCH is ignored.
- Arithmetic: pc_plus4 = pc + 32'd4, modulo 2^32, so pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000. No carry out.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ready, then VALID with ack). Each memory wait cycle adds one.
- pc changes only on an accepted ack and on reset.

Decomposition:
- Package rv32i_pkg:
  - fetch_state_t enum {FETCH, VALID, TRAP}.
  - Constants NOP_INSTR=32'h0000_0013, PC_STEP=32'd4, DEFAULT_RESET_PC.
- One sub-module, pc_reg: XLEN-wide register with synchronous reset to RESET_PC and a load enable. pc_fetch instantiates it and keeps the FSM, instr register and misaligned flag.

Test Plan:
1. Reset then zero-wait memory (imem_ready tied 1, rdata=32'h00500093), ack each VALID with next_pc=pc_plus4 -> pc sequence 0x0, 0x4, 0x8; instr_valid every second cycle; instr=0x00500093.
2. Memory with 3 wait cycles, next_pc=32'h0000_0100 on ack -> imem_req held 4 cycles with imem_addr stable; then pc=0x100 and imem_addr=0x100.
3. In VALID assert stall=1 and instr_ack=1 for 2 cycles, then stall=0 -> pc and instr unchanged during the stall; pc updates on the first unstalled ack.
4. Ack with next_pc=32'h0000_0102 -> misaligned=1, pc=0x102, imem_req=0 forever; imem_ready pulses are ignored; rst clears everything to pc=RESET_PC.
5. rst asserted mid-FETCH with imem_ready arriving the same cycle -> pc=RESET_PC, instr=NOP, instr_valid=0; the returned data is discarded.
6. Wrap: RESET_PC=32'hFFFF_FFFC -> pc_plus4=0x0; ack with next_pc=pc_plus4 gives pc=0x0 and the fetch continues.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I front end: the fetch FSM state encoding
// and constants used by the PC / fetch logic.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  // Fetch FSM states, encoded explicitly so every consumer agrees
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0 -- presented to decode while no real instruction is held
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : rv32i_pkg

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// XLEN-wide program counter register with synchronous active-high reset
// to RESET_PC and a load enable.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset (priority over load)
//   i_load  - load i_d into the register
//   i_d     - value to load
//   o_q     - current register value
// ---------------------------------------------------------------------------
module pc_reg
  import rv32i_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN-1:0] r_q;

  // PC storage: reset wins, otherwise load when enabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RESET_PC;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule : pc_reg

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Holds the architectural PC, fetches the instruction at that PC through a
// req/ready handshake and presents it to decode with a valid/ack handshake.
// An accepted next PC that is not word aligned raises a sticky misaligned
// flag and parks the fetch unit in TRAP until reset.
// Ports:
//   i_clk, i_rst      - clock and synchronous active-high reset
//   i_next_pc         - next PC from the next-PC mux
//   o_pc, o_pc_plus4  - current PC and PC + 4 (combinational)
//   o_imem_req/addr   - fetch request and address (address == o_pc)
//   i_imem_ready/rdata- memory response, sampled only while o_imem_req=1
//   o_instr/valid     - registered instruction and its valid flag
//   i_instr_ack       - decode consumed o_instr, i_next_pc is valid
//   i_stall           - hold the current instruction, blocks PC update
//   o_misaligned      - sticky misaligned-next-PC flag
// ---------------------------------------------------------------------------
module pc_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_next_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  input  logic            i_instr_ack,
  input  logic            i_stall,
  output logic            o_misaligned
);

  fetch_state_t    r_state;
  logic            r_imem_req;
  logic            r_instr_valid;
  logic            r_misaligned;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] w_pc;
  logic            w_pc_load;
  logic            w_accept;

  // An ack is accepted only while an instruction is held and not stalled
  assign w_accept  = (r_state == VALID) && i_instr_ack && !i_stall;
  assign w_pc_load = w_accept;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_pc_load),
    .i_d    (i_next_pc),
    .o_q    (w_pc)
  );

  // Fetch FSM with registered handshake outputs, instr register and trap flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= FETCH;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_instr       <= NOP_INSTR;
    end else begin
      case (r_state)
        FETCH: begin
          // ready only counts while the request is actually on the bus,
          // so the idle cycle after reset never captures stale data
          if (r_imem_req && i_imem_ready) begin
            r_instr       <= i_imem_rdata;
            r_state       <= VALID;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end else begin
            r_state       <= FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        VALID: begin
          if (w_accept) begin
            r_instr_valid <= 1'b0;
            if (i_next_pc[1:0] == 2'b00) begin
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end else begin
              r_state      <= TRAP;
              r_imem_req   <= 1'b0;
              r_misaligned <= 1'b1;
            end
          end else begin
            r_state       <= VALID;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        TRAP: begin
          r_state       <= TRAP;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_misaligned  <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fall back to a quiet fetch restart
          r_state       <= FETCH;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = w_pc;
  assign o_pc_plus4    = w_pc + PC_STEP;  // wraps modulo 2^32
  assign o_imem_addr   = w_pc;
  assign o_imem_req    = r_imem_req;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_misaligned  = r_misaligned;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Directed bench for pc_fetch. Instance a uses RESET_PC=0, instance b uses
// RESET_PC=32'hFFFF_FFFC to exercise PC wrap-around.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // instance a
  logic        rst, imem_ready, instr_ack, stall;
  logic [31:0] next_pc, imem_rdata;
  logic [31:0] pc, pc_plus4, imem_addr, instr;
  logic        imem_req, instr_valid, misaligned;

  // instance b
  logic        b_rst, b_imem_ready, b_instr_ack, b_stall;
  logic [31:0] b_next_pc, b_imem_rdata;
  logic [31:0] b_pc, b_pc_plus4, b_imem_addr, b_instr;
  logic        b_imem_req, b_instr_valid, b_misaligned;

  pc_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_next_pc(next_pc), .o_pc(pc),
    .o_pc_plus4(pc_plus4), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata), .o_instr(instr),
    .o_instr_valid(instr_valid), .i_instr_ack(instr_ack), .i_stall(stall),
    .o_misaligned(misaligned)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_next_pc(b_next_pc), .o_pc(b_pc),
    .o_pc_plus4(b_pc_plus4), .o_imem_req(b_imem_req), .o_imem_addr(b_imem_addr),
    .i_imem_ready(b_imem_ready), .i_imem_rdata(b_imem_rdata), .o_instr(b_instr),
    .o_instr_valid(b_instr_valid), .i_instr_ack(b_instr_ack), .i_stall(b_stall),
    .o_misaligned(b_misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; next_pc = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    instr_ack = 1'b0; stall = 1'b0;
    b_rst = 1'b1; b_next_pc = 32'd0; b_imem_ready = 1'b0; b_imem_rdata = 32'd0;
    b_instr_ack = 1'b0; b_stall = 1'b0;

    // ---- reset state
    tick();
    chk ("rst_pc",       pc,          32'h0000_0000);
    chk ("rst_pc_plus4", pc_plus4,    32'h0000_0004);
    chk ("rst_instr",    instr,       32'h0000_0013);
    chk1("rst_valid",    instr_valid, 1'b0);
    chk1("rst_req",      imem_req,    1'b0);
    chk1("rst_misalign", misaligned,  1'b0);

    // ---- 1: zero-wait memory, sequential PCs
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    instr_ack = 1'b1; next_pc = 32'h0000_0004;
    tick();
    chk1("t1_req0",   imem_req,    1'b1);
    chk ("t1_addr0",  imem_addr,   32'h0000_0000);
    chk1("t1_val0",   instr_valid, 1'b0);
    tick();
    chk1("t1_val1",   instr_valid, 1'b1);
    chk1("t1_req1",   imem_req,    1'b0);
    chk ("t1_instr1", instr,       32'h0050_0093);
    chk ("t1_pc1",    pc,          32'h0000_0000);
    tick();
    chk ("t1_pc4",    pc,          32'h0000_0004);
    chk ("t1_addr4",  imem_addr,   32'h0000_0004);
    chk1("t1_val2",   instr_valid, 1'b0);
    chk1("t1_req2",   imem_req,    1'b1);
    next_pc = 32'h0000_0008;
    tick();
    chk1("t1_val3",   instr_valid, 1'b1);
    tick();
    chk ("t1_pc8",    pc,          32'h0000_0008);
    chk1("t1_req3",   imem_req,    1'b1);

    // ---- 2: three wait cycles, request and address held
    imem_ready = 1'b0; instr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t2_req_hold",  imem_req,    1'b1);
      chk ("t2_addr_hold", imem_addr,   32'h0000_0008);
      chk1("t2_val_low",   instr_valid, 1'b0);
    end
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    chk1("t2_val",   instr_valid, 1'b1);
    chk ("t2_instr", instr,       32'h00A0_0113);
    imem_ready = 1'b0; instr_ack = 1'b1; next_pc = 32'h0000_0100;
    tick();
    chk ("t2_pc",   pc,        32'h0000_0100);
    chk ("t2_addr", imem_addr, 32'h0000_0100);
    chk1("t2_req",  imem_req,  1'b1);

    // ---- 3: stall overrides ack
    imem_ready = 1'b1; imem_rdata = 32'h0020_81B3; instr_ack = 1'b0;
    tick();
    chk ("t3_instr", instr, 32'h0020_81B3);
    stall = 1'b1; instr_ack = 1'b1; next_pc = 32'h0000_0104;
    imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk ("t3_pc_held",    pc,          32'h0000_0100);
      chk ("t3_instr_held", instr,       32'h0020_81B3);
      chk1("t3_val_held",   instr_valid, 1'b1);
      chk1("t3_req_low",    imem_req,    1'b0);
    end
    stall = 1'b0;
    tick();
    chk ("t3_pc_upd", pc,          32'h0000_0104);
    chk1("t3_req",    imem_req,    1'b1);
    chk1("t3_val",    instr_valid, 1'b0);

    // ---- 4: misaligned next PC traps
    imem_rdata = 32'h1234_5678; instr_ack = 1'b0;
    tick();
    chk1("t4_val", instr_valid, 1'b1);
    instr_ack = 1'b1; next_pc = 32'h0000_0102;
    tick();
    chk1("t4_mis", misaligned,  1'b1);
    chk ("t4_pc",  pc,          32'h0000_0102);
    chk1("t4_req", imem_req,    1'b0);
    chk1("t4_val0", instr_valid, 1'b0);
    instr_ack = 1'b0; next_pc = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      imem_ready = ~imem_ready;
      instr_ack  = ~instr_ack;
      tick();
      chk1("t4_trap_req", imem_req,    1'b0);
      chk1("t4_trap_val", instr_valid, 1'b0);
      chk1("t4_trap_mis", misaligned,  1'b1);
      chk ("t4_trap_pc",  pc,          32'h0000_0102);
    end
    rst = 1'b1; instr_ack = 1'b0;
    tick();
    chk ("t4_rst_pc",    pc,          32'h0000_0000);
    chk1("t4_rst_mis",   misaligned,  1'b0);
    chk ("t4_rst_instr", instr,       32'h0000_0013);
    chk1("t4_rst_val",   instr_valid, 1'b0);
    chk1("t4_rst_req",   imem_req,    1'b0);

    // ---- 5: reset during an outstanding fetch with a coincident ready
    rst = 1'b0; imem_ready = 1'b0;
    tick();
    tick();
    chk1("t5_req", imem_req, 1'b1);
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk ("t5_pc",    pc,          32'h0000_0000);
    chk ("t5_instr", instr,       32'h0000_0013);
    chk1("t5_val",   instr_valid, 1'b0);
    chk1("t5_req0",  imem_req,    1'b0);
    rst = 1'b0;
    tick();
    chk1("t5_late_val",   instr_valid, 1'b0);
    chk ("t5_late_instr", instr,       32'h0000_0013);
    chk1("t5_req1",       imem_req,    1'b1);

    // ---- 6: PC wrap with RESET_PC = 0xFFFF_FFFC
    b_rst = 1'b1;
    tick();
    chk ("t6_rst_pc", b_pc,       32'hFFFF_FFFC);
    chk ("t6_plus4",  b_pc_plus4, 32'h0000_0000);
    b_rst = 1'b0; b_imem_ready = 1'b1; b_imem_rdata = 32'h0010_0073;
    b_instr_ack = 1'b1; b_next_pc = 32'h0000_0000;
    tick();
    chk1("t6_req0", b_imem_req,  1'b1);
    chk ("t6_addr", b_imem_addr, 32'hFFFF_FFFC);
    tick();
    chk1("t6_val",   b_instr_valid, 1'b1);
    chk ("t6_instr", b_instr,       32'h0010_0073);
    tick();
    chk ("t6_pc_wrap",   b_pc,         32'h0000_0000);
    chk ("t6_addr_wrap", b_imem_addr,  32'h0000_0000);
    chk1("t6_req1",      b_imem_req,   1'b1);
    chk1("t6_mis",       b_misaligned, 1'b0);
    tick();
    chk1("t6_val2", b_instr_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_fetch
